// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: issues PCs to instruction memory, pairs in-order
// responses with their PCs and queues them for decode; flush drops all in-flight work.
module inst_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o,
  input  logic              id_ready_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] live_cnt_reg, stale_cnt_reg, fifo_cnt_reg;
  logic [CW-1:0] live_cnt_next, stale_cnt_next, fifo_cnt_next;
  logic [PW-1:0] fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [PW-1:0] pcq_wr_ptr_reg, pcq_rd_ptr_reg;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [ADDR_W-1:0] pcq_mem  [DEPTH];

  logic [CW:0] in_use;
  logic        grant;
  logic        rsp_take;
  logic        rsp_stale;
  logic        rsp_any;
  logic        fifo_push;
  logic        fifo_pop;

  // Credit check uses registered counts only, so a pop this cycle frees no slot yet.
  assign in_use = {1'b0, live_cnt_reg} + {1'b0, stale_cnt_reg} + {1'b0, fifo_cnt_reg};
  assign imem_req_o  = !rst && pc_valid_i && !flush_i && (in_use < (CW+1)'(DEPTH));
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_ready_o  = grant;

  assign rsp_stale = imem_rvalid_i && (stale_cnt_reg != '0);
  assign rsp_take  = !rst && imem_rvalid_i && !flush_i && (stale_cnt_reg == '0) && (live_cnt_reg != '0);
  assign rsp_any   = imem_rvalid_i && ((stale_cnt_reg != '0) || (live_cnt_reg != '0));
  assign fifo_push = rsp_take;
  assign fifo_pop  = id_valid_o && id_ready_i && !flush_i;

  assign id_valid_o = !rst && (fifo_cnt_reg != '0);
  assign id_inst_o  = id_valid_o ? inst_mem[fifo_rd_ptr_reg] : '0;
  assign id_pc_o    = id_valid_o ? pc_mem[fifo_rd_ptr_reg]   : '0;

  always_comb begin
    live_cnt_next  = live_cnt_reg;
    stale_cnt_next = stale_cnt_reg;
    fifo_cnt_next  = fifo_cnt_reg;
    if (flush_i) begin
      // Every live fetch becomes stale, except one whose response lands right now.
      live_cnt_next  = '0;
      fifo_cnt_next  = '0;
      stale_cnt_next = stale_cnt_reg + live_cnt_reg - CW'(rsp_any);
    end else begin
      live_cnt_next  = live_cnt_reg + CW'(grant) - CW'(rsp_take);
      stale_cnt_next = stale_cnt_reg - CW'(rsp_stale);
      fifo_cnt_next  = fifo_cnt_reg + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_cnt_reg    <= '0;
      stale_cnt_reg   <= '0;
      fifo_cnt_reg    <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      pcq_wr_ptr_reg  <= '0;
      pcq_rd_ptr_reg  <= '0;
    end else begin
      live_cnt_reg  <= live_cnt_next;
      stale_cnt_reg <= stale_cnt_next;
      fifo_cnt_reg  <= fifo_cnt_next;
      if (flush_i) begin
        fifo_wr_ptr_reg <= '0;
        fifo_rd_ptr_reg <= '0;
        pcq_wr_ptr_reg  <= '0;
        pcq_rd_ptr_reg  <= '0;
      end else begin
        fifo_wr_ptr_reg <= fifo_wr_ptr_reg + PW'(fifo_push);
        fifo_rd_ptr_reg <= fifo_rd_ptr_reg + PW'(fifo_pop);
        pcq_wr_ptr_reg  <= pcq_wr_ptr_reg + PW'(grant);
        pcq_rd_ptr_reg  <= pcq_rd_ptr_reg + PW'(rsp_take);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (grant) begin
      pcq_mem[pcq_wr_ptr_reg] <= pc_i;
    end
    if (fifo_push) begin
      inst_mem[fifo_wr_ptr_reg] <= imem_rdata_i;
      pc_mem[fifo_wr_ptr_reg]   <= pcq_mem[pcq_rd_ptr_reg];
    end
  end

endmodule
